tt_dpll_acq_ctrl: RTL

- Acquisition and lock sequencer for the DPLL. Runs on the reference clock.
- Performs a binary search of the coarse DCO code with the loop open, then closes the loop with a clean LPF state and declares lock with hysteresis.
- Recovers automatically from loss of lock.
- Sits beside the PFD/LPF/DCO and drives their coarse-code, loop-enable and filter-clear controls.

---
 rtl/tt_dpll_pkg.sv | 31 +++
 rtl/tt_dpll_updn_acc.sv | 94 +++++++++
 rtl/tt_dpll_acq_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_dpll_pkg.sv
// Shared types and width helpers for the DPLL acquisition controller.
package tt_dpll_pkg;

  localparam int unsigned DEF_CODE_W = 6;
  localparam int unsigned RELOCK_W   = 8;

  typedef enum logic [2:0] {
    ACQ_IDLE     = 3'd0,
    ACQ_C_SET    = 3'd1,
    ACQ_C_MEAS   = 3'd2,
    ACQ_C_DECIDE = 3'd3,
    ACQ_FINE     = 3'd4,
    ACQ_LOCKED   = 3'd5
  } acq_state_t;

  // Width of a counter that must hold 0..n without wrapping.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Signed up/down accumulator width; +/-settle always fits.
  function automatic int unsigned acc_w(input int unsigned settle);
    return $clog2(settle) + 2;
  endfunction

  // Bit-index width for the coarse binary search (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned code_w);
    return (code_w > 1) ? $clog2(code_w) : 1;
  endfunction

endpackage

// File: rtl/tt_dpll_updn_acc.sv
// Up/down evidence collector: signed trial accumulator plus
// consecutive quiet/active run counters with terminal-count compares.
module tt_dpll_updn_acc
  import tt_dpll_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_up,
  input  logic i_down,
  input  logic i_acc_clr,
  input  logic i_acc_en,
  input  logic i_quiet_clr,
  input  logic i_quiet_en,
  input  logic i_act_clr,
  input  logic i_act_en,
  output logic o_acc_pos_c,
  output logic o_quiet_tc_c,
  output logic o_act_tc_c
);

  localparam int unsigned ACC_W = acc_w(SETTLE_CYC);
  localparam int unsigned QW    = cnt_w(LOCK_CNT);
  localparam int unsigned AW    = cnt_w(UNLOCK_CNT);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [QW-1:0]           quiet_cnt_q, quiet_cnt_d;
  logic [AW-1:0]           act_cnt_q, act_cnt_d;
  logic                    quiet;

  assign quiet = !i_up && !i_down;

  // Accumulate net up-minus-down over one coarse trial.
  always_comb begin
    acc_d = acc_q;
    if (i_acc_clr) begin
      acc_d = '0;
    end else if (i_acc_en) begin
      if (i_up && !i_down) begin
        acc_d = acc_q + ACC_W'(1);
      end else if (i_down && !i_up) begin
        acc_d = acc_q - ACC_W'(1);
      end
    end
  end

  // Consecutive quiet run (lock) and active run (unlock) counters.
  always_comb begin
    quiet_cnt_d = quiet_cnt_q;
    act_cnt_d   = act_cnt_q;
    if (i_quiet_clr) begin
      quiet_cnt_d = '0;
    end else if (i_quiet_en) begin
      if (!quiet) begin
        quiet_cnt_d = '0;
      end else if (quiet_cnt_q != QW'(LOCK_CNT)) begin
        quiet_cnt_d = quiet_cnt_q + QW'(1);
      end
    end
    if (i_act_clr) begin
      act_cnt_d = '0;
    end else if (i_act_en) begin
      if (quiet) begin
        act_cnt_d = '0;
      end else if (act_cnt_q != AW'(UNLOCK_CNT)) begin
        act_cnt_d = act_cnt_q + AW'(1);
      end
    end
  end

  // Terminal counts fire on the cycle whose edge completes the run.
  assign o_quiet_tc_c = i_quiet_en && !i_quiet_clr && quiet &&
                        (quiet_cnt_q == QW'(LOCK_CNT - 1));
  assign o_act_tc_c   = i_act_en && !i_act_clr && !quiet &&
                        (act_cnt_q == AW'(UNLOCK_CNT - 1));
  assign o_acc_pos_c  = !acc_q[ACC_W-1] && (acc_q != '0);

  // Evidence state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      quiet_cnt_q <= '0;
      act_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      quiet_cnt_q <= quiet_cnt_d;
      act_cnt_q   <= act_cnt_d;
    end
  end

endmodule

// File: rtl/tt_dpll_acq_ctrl.sv
// DPLL acquisition/lock sequencer: coarse binary search with the loop
// open, then closed-loop fine tracking with lock/unlock hysteresis.
// Optional macro TT_DPLL_ACQ_CTRL_RELOCK_CNT_EN adds o_relock_cnt.
module tt_dpll_acq_ctrl
  import tt_dpll_pkg::*;
#(
  parameter int unsigned CODE_W      = DEF_CODE_W,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned UNLOCK_CNT  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              i_clk_ref,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_up,
  input  logic              i_down,
  output logic [CODE_W-1:0] o_coarse_code,
  output logic              o_loop_en,
  output logic              o_lpf_clr,
  output logic              o_locked,
  output logic [2:0]        o_state
`ifdef TT_DPLL_ACQ_CTRL_RELOCK_CNT_EN
  ,
  output logic [RELOCK_W-1:0] o_relock_cnt
`endif
);

  localparam logic [2:0] S_IDLE     = 3'(ACQ_IDLE);
  localparam logic [2:0] S_C_SET    = 3'(ACQ_C_SET);
  localparam logic [2:0] S_C_MEAS   = 3'(ACQ_C_MEAS);
  localparam logic [2:0] S_C_DECIDE = 3'(ACQ_C_DECIDE);
  localparam logic [2:0] S_FINE     = 3'(ACQ_FINE);
  localparam logic [2:0] S_LOCKED   = 3'(ACQ_LOCKED);

  localparam int unsigned IDX_W  = idx_w(CODE_W);
  localparam int unsigned MEAS_W = cnt_w(SETTLE_CYC);
  localparam int unsigned TO_W   = cnt_w(TIMEOUT_CYC);

  logic [2:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [MEAS_W-1:0] meas_q, meas_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              loop_en_q, loop_en_d;
  logic              lpf_clr_q, lpf_clr_d;
  logic              locked_q, locked_d;

  logic acc_clr, acc_en, quiet_clr, quiet_en, act_clr, act_en;
  logic acc_pos, quiet_tc, act_tc;

  tt_dpll_updn_acc #(
    .SETTLE_CYC (SETTLE_CYC),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_updn_acc (
    .clk          (i_clk_ref),
    .rst          (i_rst),
    .i_up         (i_up),
    .i_down       (i_down),
    .i_acc_clr    (acc_clr),
    .i_acc_en     (acc_en),
    .i_quiet_clr  (quiet_clr),
    .i_quiet_en   (quiet_en),
    .i_act_clr    (act_clr),
    .i_act_en     (act_en),
    .o_acc_pos_c  (acc_pos),
    .o_quiet_tc_c (quiet_tc),
    .o_act_tc_c   (act_tc)
  );

  // Next-state, coarse search, timeout and output decode.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    idx_d     = idx_q;
    meas_d    = meas_q;
    to_d      = to_q;
    loop_en_d = loop_en_q;
    lpf_clr_d = 1'b0;
    locked_d  = locked_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    quiet_en  = 1'b0;
    quiet_clr = 1'b1;
    act_en    = 1'b0;
    act_clr   = 1'b1;

    case (state_q)
      S_IDLE: begin
        code_d    = '0;
        loop_en_d = 1'b0;
        locked_d  = 1'b0;
        acc_clr   = 1'b1;
        if (i_enable) begin
          state_d = S_C_SET;
          idx_d   = IDX_W'(CODE_W - 1);
        end
      end
      S_C_SET: begin
        code_d[idx_q] = 1'b1;
        acc_clr       = 1'b1;
        meas_d        = '0;
        state_d       = S_C_MEAS;
      end
      S_C_MEAS: begin
        acc_en = 1'b1;
        meas_d = meas_q + MEAS_W'(1);
        if (meas_q == MEAS_W'(SETTLE_CYC - 1)) begin
          state_d = S_C_DECIDE;
        end
      end
      S_C_DECIDE: begin
        // A tie clears the bit, biasing toward lower frequency.
        if (!acc_pos) begin
          code_d[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = S_C_SET;
        end else begin
          lpf_clr_d = 1'b1;
          loop_en_d = 1'b1;
          to_d      = '0;
          state_d   = S_FINE;
        end
      end
      S_FINE: begin
        quiet_en  = 1'b1;
        quiet_clr = 1'b0;
        if (to_q != TO_W'(TIMEOUT_CYC)) begin
          to_d = to_q + TO_W'(1);
        end
        // Lock takes priority over a simultaneous timeout.
        if (quiet_tc) begin
          locked_d = 1'b1;
          state_d  = S_LOCKED;
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          loop_en_d = 1'b0;
          code_d    = '0;
          idx_d     = IDX_W'(CODE_W - 1);
          to_d      = '0;
          state_d   = S_C_SET;
        end
      end
      S_LOCKED: begin
        act_en  = 1'b1;
        act_clr = 1'b0;
        if (act_tc) begin
          locked_d = 1'b0;
          to_d     = '0;
          state_d  = S_FINE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping enable returns everything to the idle/reset view.
    if (!i_enable) begin
      state_d   = S_IDLE;
      code_d    = '0;
      idx_d     = '0;
      meas_d    = '0;
      to_d      = '0;
      loop_en_d = 1'b0;
      lpf_clr_d = 1'b0;
      locked_d  = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge i_clk_ref or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      idx_q     <= '0;
      meas_q    <= '0;
      to_q      <= '0;
      loop_en_q <= 1'b0;
      lpf_clr_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      meas_q    <= meas_d;
      to_q      <= to_d;
      loop_en_q <= loop_en_d;
      lpf_clr_q <= lpf_clr_d;
      locked_q  <= locked_d;
    end
  end

  assign o_coarse_code = code_q;
  assign o_loop_en     = loop_en_q;
  assign o_lpf_clr     = lpf_clr_q;
  assign o_locked      = locked_q;
  assign o_state       = state_q;

`ifdef TT_DPLL_ACQ_CTRL_RELOCK_CNT_EN
  logic [RELOCK_W-1:0] relock_q, relock_d;

  // Count LOCKED->FINE drops, saturating; cleared whenever heading to IDLE.
  always_comb begin
    relock_d = relock_q;
    if (state_d == S_IDLE) begin
      relock_d = '0;
    end else if ((state_q == S_LOCKED) && (state_d == S_FINE) &&
                 (relock_q != {RELOCK_W{1'b1}})) begin
      relock_d = relock_q + RELOCK_W'(1);
    end
  end

  // Relock counter register.
  always_ff @(posedge i_clk_ref or posedge i_rst) begin
    if (i_rst) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign o_relock_cnt = relock_q;
`endif

endmodule
